// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave family.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    // Value driven on the read data bus whenever no read is completing.
    localparam logic [31:0] PRDATA_IDLE = '0;

    // Ceiling log2, with a floor of 1 so a 2-entry file still gets an index bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module apb_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load takes priority over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave with a word-addressed register file, programmable wait states
// and PSLVERR signalling. Register 0 is a read-only ID word.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer; a setup phase (sel & ~Penable) is captured here
// SETUP  | first access-phase cycle after the captured setup phase
// ACCESS | later access-phase cycles while wait states count down
//
// SETUP and ACCESS both complete the transfer once the wait counter is zero,
// which is what lets WAIT_STATES=0 finish in the first Penable cycle.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter int          SEL_INDEX   = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic              Pclk,
    input  logic              Presetn,
    input  logic [2:0]        Pselx,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [ADDR_W-1:0] Paddr,
    input  logic [DATA_W-1:0] Pwdata,
    output logic [DATA_W-1:0] Prdata,
    output logic              Pready,
    output logic              Pslverr
);

    localparam int IDX_W = clog2(NUM_REGS);
    localparam int WA_W  = ADDR_W - 2;

    apb_state_t        state;
    apb_state_t        state_next;
    logic              sel;
    logic [WA_W-1:0]   word_addr;
    logic              addr_error;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              err_q;
    logic [3:0]        wait_cnt;
    logic              wait_zero;
    logic              cnt_load;
    logic              cnt_dec;
    logic              xfer_done;
    logic              illegal;
    logic              commit;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];
    logic              unused_bits;

    assign sel       = Pselx[SEL_INDEX];
    assign word_addr = Paddr[ADDR_W-1:2];

    // Range check uses the whole word address so an alias of a valid index
    // (e.g. word 9 with 8 registers) is rejected instead of hitting index 1.
    assign addr_error = (word_addr >= WA_W'(NUM_REGS))
                      | (Pwrite & (word_addr == '0));

    apb_wait_counter #(
        .WIDTH (4)
    ) u_wait_counter (
        .clk        (Pclk),
        .rst_n      (Presetn),
        .load       (cnt_load),
        .load_value (4'(WAIT_STATES)),
        .dec        (cnt_dec),
        .count      (wait_cnt),
        .zero       (wait_zero)
    );

    // State register.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; dropping sel or Penable mid-access abandons the transfer.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            IDLE: begin
                if (sel && !Penable) begin
                    state_next = SETUP;
                    cnt_load   = 1'b1;
                end
            end
            SETUP, ACCESS: begin
                if (!(sel && Penable)) begin
                    state_next = IDLE;
                end else if (wait_zero) begin
                    state_next = IDLE;
                    xfer_done  = 1'b1;
                end else begin
                    state_next = ACCESS;
                    cnt_dec    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Address, direction and error status are frozen at the setup phase.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (cnt_load) begin
            idx_q   <= Paddr[IDX_W+1:2];
            write_q <= Pwrite;
            err_q   <= addr_error;
        end
    end

    // Access phase with no setup: answer with an error so the master never hangs.
    assign illegal = Presetn & (state == IDLE) & sel & Penable;
    assign commit  = xfer_done & write_q & ~err_q;

    // Register file; index 0 has no storage and is never written.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    regs[i] <= Pwdata;
                end
            end
        end
    end

    // Read mux; index 0 falls through to the ID word.
    always_comb begin
        rd_word = ID_VALUE[DATA_W-1:0];
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    assign Pready  = xfer_done | illegal;
    assign Pslverr = illegal | (xfer_done & err_q);
    assign Prdata  = (xfer_done & ~write_q & ~err_q) ? rd_word
                                                     : PRDATA_IDLE[DATA_W-1:0];

    assign unused_bits = ^{Pselx, Paddr[1:0], wait_cnt};

endmodule
